imem_dmem_arbiter: RTL

- Shares one single-port word memory between the instruction-fetch requester and the load/store requester of the multicycle RV32I core.
- Sits between the fetch/LSU stages and the unified memory macro.
- Each requester uses a valid/ready request channel and receives a response pulse.
- Exactly one transaction is in flight at a time. Data accesses have priority, with a starvation guard for fetch.

---
 rtl/imem_dmem_arbiter_if.sv | 48 ++++
 rtl/imem_dmem_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Request/response and memory-side bus shared by the fetch unit, the LSU and the memory macro.
// Latency: none, this is only a bundle of wires.
// Backpressure: request channels use valid/ready; response pulses cannot be stalled.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      if_req_valid;
  logic                      if_req_ready;
  logic [ADDR_WIDTH-1:0]     if_req_addr;
  logic                      if_rsp_valid;
  logic [DATA_WIDTH-1:0]     if_rsp_data;

  logic                      d_req_valid;
  logic                      d_req_ready;
  logic                      d_req_we;
  logic [DATA_WIDTH/8-1:0]   d_req_be;
  logic [ADDR_WIDTH-1:0]     d_req_addr;
  logic [DATA_WIDTH-1:0]     d_req_wdata;
  logic                      d_rsp_valid;
  logic [DATA_WIDTH-1:0]     d_rsp_data;

  logic                      mem_en;
  logic [DATA_WIDTH/8-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    input  mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester and memory side.
  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
    output mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store, one transaction at a time.
// Latency: accept at T, mem_en at T+1, response pulse at T+2+MEM_LATENCY.
// Backpressure: readies only in IDLE; data wins conflicts unless fetch has waited STARVE_LIMIT grants.
module imem_dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  imem_dmem_arbiter_if.slave bus
);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            cmd_is_d;
  logic            cmd_is_store;

  logic            fetch_wins;
  logic            if_grant;
  logic            d_grant;
  logic            wait_done;
  logic            unused_addr_bits;

  // Word-aligned memory: the byte offset of a request carries no meaning here.
  assign unused_addr_bits = ^{bus.if_req_addr[1:0], bus.d_req_addr[1:0]};

  // Grant selection in IDLE; at most one ready is ever high.
  always_comb begin
    fetch_wins = (STARVE_LIMIT == 0) || (int'(starve_cnt) >= STARVE_LIMIT);
    if_grant   = (state == IDLE) && !reset && bus.if_req_valid &&
                 (!bus.d_req_valid || fetch_wins);
    d_grant    = (state == IDLE) && !reset && bus.d_req_valid &&
                 !(bus.if_req_valid && fetch_wins);
    wait_done  = (int'(wait_cnt) == MEM_LATENCY);
  end

  assign bus.if_req_ready = if_grant;
  assign bus.d_req_ready  = d_grant;

  // Transaction sequencer: accept, drive the memory, wait out its latency, pulse the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      wait_cnt         <= '0;
      cmd_is_d         <= 1'b0;
      cmd_is_store     <= 1'b0;
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_data  <= '0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rsp_data   <= '0;
    end else begin
      bus.if_rsp_valid <= 1'b0;
      bus.d_rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_grant || d_grant) begin
            cmd_is_d     <= d_grant;
            cmd_is_store <= d_grant && bus.d_req_we;
            bus.mem_en   <= 1'b1;
            if (d_grant) begin
              bus.mem_addr  <= {bus.d_req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_we    <= bus.d_req_we ? bus.d_req_be : '0;
              bus.mem_wdata <= bus.d_req_wdata;
            end else begin
              bus.mem_addr  <= {bus.if_req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.mem_we    <= '0;
              bus.mem_wdata <= '0;
            end
            // Count data grants that made a waiting fetch lose.
            if (if_grant || !bus.if_req_valid) begin
              starve_cnt <= '0;
            end else if (int'(starve_cnt) < STARVE_LIMIT) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= '0;
          wait_cnt   <= WW'(1);
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_done) begin
            if (cmd_is_d) begin
              bus.d_rsp_valid <= 1'b1;
              bus.d_rsp_data  <= cmd_is_store ? '0 : bus.mem_rdata;
            end else begin
              bus.if_rsp_valid <= 1'b1;
              bus.if_rsp_data  <= bus.mem_rdata;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
